restoring_divider_param: RTL
============================

// Module: restoring_divider_param
// PURPOSE
//  Parametrised multi-cycle restoring divider. Unsigned or two's-complement signed per operation.
//  Start/busy/valid handshake; flags divide-by-zero and signed overflow.
//  Sits between the operand push registers and the seven-segment result display.
//  Display latches quotient/remainder on valid.
// PARAMETERS
//  WIDTH      16  operand/result width in bits, >= 2
//  SIGNED_EN  1   1: signed_mode port honoured; 0: signed_mode ignored, always unsigned
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      reset, asynchronous, active-high
//  start        in   1      request; sampled only when busy=0
//  signed_mode  in   1      1 = signed op; sampled with start
//  dividend     in   WIDTH  numerator; sampled with start
//  divisor      in   WIDTH  denominator; sampled with start
//  busy         out  1      high while an operation is in progress
//  valid        out  1      one-cycle pulse; results updated on this cycle
//  quotient     out  WIDTH  result, held until next valid
//  remainder    out  WIDTH  result, held until next valid
//  div_by_zero  out  1      sticky per result: set with valid, cleared at next accepted start
//  overflow     out  1      sticky per result: signed MIN/-1 case, cleared at next accepted start
// BEHAVIOUR
//  Reset: state IDLE; busy, valid, quotient, remainder, div_by_zero, overflow, iteration counter all 0.
//   Reset takes effect immediately, including mid-operation; the aborted op produces no valid.
//  States:
//   IDLE -> DIVIDE on start with normal operands.
//   IDLE -> IDLE on start with a special case; result published at the next edge.
//   DIVIDE -> FIX after WIDTH iterations.
//   FIX -> IDLE, asserting valid.
//  IDLE on start:
//   - Latch the sign of each operand; latched sign is 0 when unsigned.
//   - Latch operand magnitudes: abs() when signed, raw value when unsigned.
//   - Clear the accumulator (WIDTH+1 bits, so the subtraction borrow is kept).
//   - Clear both flags; set busy.
//  DIVIDE: one iteration per cycle.
//   - Shift {acc, q} left 1; trial = acc - |divisor|.
//   - Borrow: restore acc and shift in q bit 0. No borrow: acc = trial, shift in q bit 1.
//   - Counter width $clog2(WIDTH+1); runs 0..WIDTH-1.
//  FIX:
//   - Negate quotient if the operand signs differ.
//   - Negate remainder if dividend was negative.
//   - Signed quotient truncates toward zero; remainder takes the dividend's sign.
//   - Register outputs; valid=1 on the next cycle; busy=0 in that valid cycle.
//  Latency, normal op: valid is high in the cycle after the (WIDTH+2)th rising edge counted from the edge that samples start.
//  Special cases, checked in IDLE (busy never asserts):
//   - Divisor 0: quotient = all ones, remainder = dividend, div_by_zero=1.
//   - Signed, dividend = MIN (1 followed by zeros), divisor = all ones:
//     quotient = MIN, remainder = 0, overflow=1.
//   - Divisor 0 takes priority over overflow.
//   - valid is high in the cycle after the sampling edge.
//  Boundaries:
//   - start while busy=1: ignored, no queueing.
//   - start in the valid cycle: accepted (back-to-back operation).
//   - Operand inputs may change freely while busy.
//   - Outputs are stable between valid pulses.
//   - Unsigned |dividend| < |divisor| gives quotient 0, remainder = dividend.
//   - WIDTH-bit MIN magnitude is represented correctly, because the magnitude path is WIDTH+1 bits.
// TESTING (WIDTH=16)
//  1. Unsigned 100/7: q=14, r=2, valid exactly 18 cycles after the start edge; busy high 17 cycles.
//  2. Signed -100/7: q=0xFFF2, r=0xFFFE. Signed 100/-7: q=0xFFF2, r=0x0002.
//  3. Divisor 0, dividend 0x1234: next cycle valid=1, q=0xFFFF, r=0x1234, div_by_zero=1.
//  4. Signed 0x8000/0xFFFF: next cycle valid=1, q=0x8000, r=0, overflow=1.
//     Same operands unsigned: q=0x0000, r=0x8000, no flags.
//  5. Start at iteration 5 with other operands: ignored, first result unchanged.
//     Start held in the valid cycle: second op starts; its valid arrives 18 cycles later.
//  6. rst asserted at iteration 8: all outputs 0 immediately, no valid.
//     After release, 0xFFFF/1 gives q=0xFFFF, r=0.

Source files
------------

// File: rtl/restoring_divider_param.sv
// ---------------------------------------------------------------------------
// restoring_divider_param
//
// Multi-cycle restoring divider with a start/busy/valid handshake. Each
// operation is unsigned, or two's-complement signed when signed_mode is set
// and SIGNED_EN is 1. Divide-by-zero and signed MIN/-1 are resolved in one
// cycle without entering the iteration loop. Otherwise the magnitudes are
// divided one bit per cycle, and the signs are applied in a final fix-up
// cycle.
//
// Ports
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous active-high reset
//   start        in   1      operation request, sampled only while busy=0
//   signed_mode  in   1      1 = signed operation, sampled with start
//   dividend     in   WIDTH  numerator, sampled with start
//   divisor      in   WIDTH  denominator, sampled with start
//   busy         out  1      high while an operation is in progress
//   valid        out  1      one-cycle pulse when results are updated
//   quotient     out  WIDTH  result, held until the next valid
//   remainder    out  WIDTH  result, held until the next valid
//   div_by_zero  out  1      set with valid, cleared at the next accepted start
//   overflow     out  1      signed MIN/-1, cleared at the next accepted start
// ---------------------------------------------------------------------------
module restoring_divider_param #(
    parameter int WIDTH     = 16,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIVIDE, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH:0]   dvs_mag;
    logic             dvd_neg_r;
    logic             dvs_neg_r;

    logic             op_signed;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH:0]   dvs_ext;
    logic [WIDTH:0]   dvs_mag_next;
    logic             is_zero;
    logic             is_ovf;
    logic [WIDTH+1:0] acc_shift;
    logic [WIDTH+1:0] trial;
    logic             borrow;

    // Operand decode for the cycle in which start is sampled.
    // A WIDTH-bit unsigned value holds |MIN| = 2^(WIDTH-1) exactly, so the
    // dividend magnitude needs no extra bit. The divisor magnitude is kept
    // WIDTH+1 bits wide because it feeds the WIDTH+2 bit trial subtraction.
    always_comb begin
        op_signed    = SIGNED_EN & signed_mode;
        dvd_neg      = op_signed & dividend[WIDTH-1];
        dvs_neg      = op_signed & divisor[WIDTH-1];
        dvd_mag      = dvd_neg ? WIDTH'(-dividend) : dividend;
        dvs_ext      = {dvs_neg, divisor};
        dvs_mag_next = dvs_neg ? (WIDTH+1)'(-dvs_ext) : dvs_ext;
        is_zero      = (divisor == '0);
        is_ovf       = op_signed && (dividend == MIN_VAL) && (divisor == '1);
    end

    // One restoring step. The partial remainder is always below the divisor,
    // so one extra top bit on the trial difference is enough to read the
    // borrow.
    always_comb begin
        acc_shift = {acc, work_q[WIDTH-1]};
        trial     = acc_shift - {1'b0, dvs_mag};
        borrow    = trial[WIDTH+1];
    end

    // Control FSM and datapath registers. valid defaults low so that it
    // pulses for exactly one cycle. The results and flags are written only
    // when a result is published, so they stay stable between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            acc         <= '0;
            work_q      <= '0;
            dvs_mag     <= '0;
            dvd_neg_r   <= 1'b0;
            dvs_neg_r   <= 1'b0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        if (is_zero) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            valid       <= 1'b1;
                        end else if (is_ovf) begin
                            quotient  <= MIN_VAL;
                            remainder <= '0;
                            overflow  <= 1'b1;
                            valid     <= 1'b1;
                        end else begin
                            dvd_neg_r <= dvd_neg;
                            dvs_neg_r <= dvs_neg;
                            work_q    <= dvd_mag;
                            dvs_mag   <= dvs_mag_next;
                            acc       <= '0;
                            count     <= '0;
                            busy      <= 1'b1;
                            state     <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    acc    <= borrow ? acc_shift[WIDTH:0] : trial[WIDTH:0];
                    work_q <= {work_q[WIDTH-2:0], ~borrow};
                    count  <= count + CW'(1);
                    if (count == LAST_ITER) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // Truncating division: the quotient takes the sign of
                    // the product of the signs, and the remainder takes the
                    // dividend's sign.
                    quotient  <= (dvd_neg_r ^ dvs_neg_r) ? WIDTH'(-work_q) : work_q;
                    remainder <= dvd_neg_r ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
                    valid     <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
